// File: rtl/wf_slot_manager_if.sv
// Handshake and generator-facing bundle for wf_slot_manager.
// master = slot manager side, slave = dispatcher / issue / WF-id generator side.
interface wf_slot_manager_if #(
    parameter int NUM_WF = 40,
    parameter int ID_W   = 6,
    parameter int TAG_W  = 15
);
    logic              dispatch_valid;
    logic [TAG_W-1:0]  dispatch_tag;
    logic              dispatch_ready;
    logic              new_wf_valid;
    logic [ID_W-1:0]   new_wf_id;
    logic [TAG_W-1:0]  new_wf_tag;
    logic              halt_valid;
    logic [ID_W-1:0]   halt_wfid;
    logic              halt_ready;
    logic              done_valid;
    logic [ID_W-1:0]   done_wfid;
    logic [TAG_W-1:0]  done_tag;
    logic              done_ready;
    logic [ID_W-1:0]   free_count;
    logic              gen_wr;
    logic [TAG_W-1:0]  gen_tag;
    logic              gen_halt;
    logic [ID_W-1:0]   gen_id_done;
    logic [NUM_WF-1:0] gen_vacant;
    logic [ID_W-1:0]   gen_wf_id;
    logic [NUM_WF-1:0] gen_vacant_nxt;
    logic [TAG_W-1:0]  gen_tag_done;
    logic              err;

    modport master (
        input  dispatch_valid, dispatch_tag, halt_valid, halt_wfid, done_ready,
               gen_wf_id, gen_vacant_nxt, gen_tag_done,
        output dispatch_ready, new_wf_valid, new_wf_id, new_wf_tag, halt_ready,
               done_valid, done_wfid, done_tag, free_count, gen_wr, gen_tag,
               gen_halt, gen_id_done, gen_vacant, err
    );

    modport slave (
        output dispatch_valid, dispatch_tag, halt_valid, halt_wfid, done_ready,
               gen_wf_id, gen_vacant_nxt, gen_tag_done,
        input  dispatch_ready, new_wf_valid, new_wf_id, new_wf_tag, halt_ready,
               done_valid, done_wfid, done_tag, free_count, gen_wr, gen_tag,
               gen_halt, gen_id_done, gen_vacant, err
    );
endinterface

// File: rtl/wf_slot_manager.sv
// Wavefront slot vacancy owner: dispatch alloc via WF-id generator, halt queue frees slots on completion pop.
// Latency: new_wf_* 1 cycle after accept; done_* visible 1 cycle after halt push; slot freed on pop.
// Backpressure: dispatch_ready=0 when no slot vacant; halt_ready=0 when halt FIFO full. Optional WF_SLOT_ERR_CHECK_EN drops bad halts.
module wf_slot_manager #(
    parameter int NUM_WF    = 40,
    parameter int ID_W      = 6,
    parameter int TAG_W     = 15,
    parameter int HFIFO_DEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    wf_slot_manager_if.master  bus
);
    localparam int PTR_W = $clog2(HFIFO_DEP);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_WF-1:0] vacant_q;
    logic [ID_W-1:0]   free_q;
    logic              new_vld_q;
    logic [ID_W-1:0]   new_id_q;
    logic [TAG_W-1:0]  new_tag_q;

    logic [ID_W-1:0]   fifo_mem [HFIFO_DEP];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;

    logic full, empty, alloc, pop, push_bad, push_ok;

    assign full  = (cnt == CNT_W'(HFIFO_DEP));
    assign empty = (cnt == '0);
    assign alloc = bus.dispatch_valid & (|vacant_q);
    assign pop   = ~empty & bus.done_ready;

`ifdef WF_SLOT_ERR_CHECK_EN
    logic err_q;
    // Out-of-range ids are rejected before the vacancy lookup so the index stays legal.
    assign push_bad = (bus.halt_wfid >= ID_W'(NUM_WF)) ? 1'b1 : vacant_q[bus.halt_wfid];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (bus.halt_valid & ~full & push_bad)
            err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign push_bad = 1'b0;
    assign bus.err  = 1'b0;
`endif

    assign push_ok = bus.halt_valid & ~full & ~push_bad;

    assign bus.dispatch_ready = |vacant_q;
    assign bus.gen_wr         = alloc;
    assign bus.gen_tag        = bus.dispatch_tag;
    assign bus.new_wf_valid   = new_vld_q;
    assign bus.new_wf_id      = new_id_q;
    assign bus.new_wf_tag     = new_tag_q;
    assign bus.halt_ready     = ~full;
    assign bus.done_valid     = ~empty;
    assign bus.done_wfid      = fifo_mem[rd_ptr];
    assign bus.done_tag       = bus.gen_tag_done;
    assign bus.gen_halt       = pop;
    assign bus.gen_id_done    = fifo_mem[rd_ptr];
    assign bus.gen_vacant     = vacant_q;
    assign bus.free_count     = free_q;

    // The generator resolves alloc and free together; its vacant_next is the new truth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vacant_q  <= '1;
            free_q    <= ID_W'(NUM_WF);
            new_vld_q <= 1'b0;
            new_id_q  <= '0;
            new_tag_q <= '0;
        end else begin
            vacant_q  <= bus.gen_vacant_nxt;
            free_q    <= free_q - {{(ID_W-1){1'b0}}, alloc} + {{(ID_W-1){1'b0}}, pop};
            new_vld_q <= alloc;
            if (alloc) begin
                new_id_q  <= bus.gen_wf_id;
                new_tag_q <= bus.dispatch_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= bus.halt_wfid;
    end
endmodule

// File: tb/tb_wf_slot_manager.sv
// Directed bench for wf_slot_manager with a behavioural WF-id generator and alloc/done scoreboards.
module tb_wf_slot_manager;
    localparam int NUM_WF = 40;
    localparam int ID_W   = 6;
    localparam int TAG_W  = 15;

    typedef struct {
        int          id;
        logic [14:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wf_slot_manager_if #(.NUM_WF(NUM_WF), .ID_W(ID_W), .TAG_W(TAG_W)) bus ();

    wf_slot_manager #(.NUM_WF(NUM_WF), .ID_W(ID_W), .TAG_W(TAG_W), .HFIFO_DEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Generator model: lowest vacant id, wr clears and halt sets in the same update.
    logic [TAG_W-1:0] gen_tags [64];
    always_comb begin
        bus.gen_wf_id = '0;
        for (int i = NUM_WF - 1; i >= 0; i--)
            if (bus.gen_vacant[i]) bus.gen_wf_id = ID_W'(i);
    end
    always_comb begin
        bus.gen_vacant_nxt = bus.gen_vacant;
        if (bus.gen_wr)   bus.gen_vacant_nxt[bus.gen_wf_id]   = 1'b0;
        if (bus.gen_halt) bus.gen_vacant_nxt[bus.gen_id_done] = 1'b1;
    end
    assign bus.gen_tag_done = gen_tags[bus.gen_id_done];
    always @(posedge clk) if (bus.gen_wr) gen_tags[bus.gen_wf_id] <= bus.gen_tag;

    int checks = 0;
    int errors = 0;
    logic [NUM_WF-1:0] m_vac = '1;
    logic [TAG_W-1:0]  m_tag [NUM_WF];
    int   free_exp = NUM_WF;
    exp_t exp_new [$];
    exp_t exp_done [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [NUM_WF-1:0] v);
        for (int i = 0; i < NUM_WF; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_new.size() > 0) begin
            e = exp_new.pop_front();
            check("new_wf_valid", bus.new_wf_valid, 1);
            check("new_wf_id", bus.new_wf_id, e.id);
            check("new_wf_tag", bus.new_wf_tag, e.tag);
        end else begin
            check("new_wf_idle", bus.new_wf_valid, 0);
        end
        check("free_count", bus.free_count, free_exp);
        check("gen_vacant", bus.gen_vacant, m_vac);
    endtask

    // Record an allocation the bench expects in the current cycle.
    task automatic model_alloc(input logic [TAG_W-1:0] tag);
        exp_t e;
        e.id  = lowest(m_vac);
        e.tag = tag;
        exp_new.push_back(e);
        m_vac[e.id] = 1'b0;
        m_tag[e.id] = tag;
        free_exp--;
    endtask

    task automatic do_dispatch(input logic [TAG_W-1:0] tag);
        bus.dispatch_valid = 1'b1;
        bus.dispatch_tag   = tag;
        #2;
        check("gen_wr", bus.gen_wr, 1);
        check("gen_tag", bus.gen_tag, tag);
        model_alloc(tag);
        tick();
        bus.dispatch_valid = 1'b0;
    endtask

    task automatic push_halt(input int id);
        exp_t e;
        bus.halt_valid = 1'b1;
        bus.halt_wfid  = ID_W'(id);
        #2;
        check("halt_ready", bus.halt_ready, 1);
        e.id  = id;
        e.tag = m_tag[id];
        exp_done.push_back(e);
        tick();
        bus.halt_valid = 1'b0;
    endtask

    // Caller has raised done_ready and let it settle.
    task automatic expect_pop();
        exp_t e;
        check("gen_halt_pop", bus.gen_halt, 1);
        if (exp_done.size() == 0) begin
            check("done_sb_underflow", 1, 0);
        end else begin
            e = exp_done.pop_front();
            check("done_wfid", bus.done_wfid, e.id);
            check("gen_id_done", bus.gen_id_done, e.id);
            check("done_tag", bus.done_tag, e.tag);
            m_vac[e.id] = 1'b1;
            free_exp++;
        end
    endtask

    initial begin
        bus.dispatch_valid = 1'b0;
        bus.dispatch_tag   = '0;
        bus.halt_valid     = 1'b0;
        bus.halt_wfid      = '0;
        bus.done_ready     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_gen_vacant", bus.gen_vacant, 40'hFF_FFFF_FFFF);
        check("rst_free_count", bus.free_count, 40);
        check("rst_dispatch_ready", bus.dispatch_ready, 1);
        check("rst_done_valid", bus.done_valid, 0);
        check("rst_halt_ready", bus.halt_ready, 1);
        check("rst_new_wf_valid", bus.new_wf_valid, 0);
        check("rst_new_wf_id", bus.new_wf_id, 0);
        check("rst_new_wf_tag", bus.new_wf_tag, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b0;
        tick();

        // First dispatch, then fill every slot back to back
        do_dispatch(15'h1234);
        for (int k = 1; k < NUM_WF; k++)
            do_dispatch((k == 5) ? 15'h00AA : 15'(16'h0100 + k));
        check("full_dispatch_ready", bus.dispatch_ready, 0);
        check("full_free_count", bus.free_count, 0);

        // 41st request is held with no allocation
        bus.dispatch_valid = 1'b1;
        bus.dispatch_tag   = 15'h7FFF;
        #2;
        check("full_gen_wr", bus.gen_wr, 0);
        tick();
        tick();
        bus.dispatch_valid = 1'b0;

        // Halt id 5, completion withheld for three cycles
        push_halt(5);
        for (int c = 0; c < 3; c++) begin
            #2;
            check("hold_done_valid", bus.done_valid, 1);
            check("hold_done_wfid", bus.done_wfid, 5);
            check("hold_done_tag", bus.done_tag, 15'h00AA);
            check("hold_gen_halt", bus.gen_halt, 0);
            tick();
        end
        bus.done_ready = 1'b1;
        #2;
        expect_pop();
        tick();
        check("after_pop_done_valid", bus.done_valid, 0);
        check("after_pop_gen_halt", bus.gen_halt, 0);
        check("slot5_vacant", bus.gen_vacant[5], 1);
        bus.done_ready = 1'b0;

        // Refill slot 5, then pop it while a dispatch waits at full occupancy
        do_dispatch(15'h00B5);
        push_halt(5);
        bus.done_ready     = 1'b1;
        bus.dispatch_valid = 1'b1;
        bus.dispatch_tag   = 15'h0555;
        #2;
        check("full_pop_gen_wr", bus.gen_wr, 0);
        expect_pop();
        tick();
        bus.done_ready = 1'b0;
        #2;
        check("realloc_gen_wr", bus.gen_wr, 1);
        model_alloc(15'h0555);
        tick();
        bus.dispatch_valid = 1'b0;

        // Simultaneous alloc and free with one slot vacant: count unchanged
        push_halt(6);
        bus.done_ready = 1'b1;
        #2;
        expect_pop();
        tick();
        bus.done_ready = 1'b0;
        push_halt(7);
        bus.done_ready     = 1'b1;
        bus.dispatch_valid = 1'b1;
        bus.dispatch_tag   = 15'h0666;
        #2;
        check("simul_gen_wr", bus.gen_wr, 1);
        model_alloc(15'h0666);
        expect_pop();
        tick();
        check("simul_free_count", bus.free_count, 1);
        bus.done_ready     = 1'b0;
        bus.dispatch_valid = 1'b0;

        // Fill the halt FIFO; the fifth halt is backpressured
        for (int h = 0; h < 4; h++) push_halt(h);
        bus.halt_valid = 1'b1;
        bus.halt_wfid  = ID_W'(4);
        #2;
        check("fifo_full_halt_ready", bus.halt_ready, 0);
        tick();
        bus.halt_valid = 1'b0;
        bus.done_ready = 1'b1;
        for (int h = 0; h < 4; h++) begin
            #2;
            expect_pop();
            tick();
        end
        bus.done_ready = 1'b0;
        check("drained_done_valid", bus.done_valid, 0);

`ifdef WF_SLOT_ERR_CHECK_EN
        // Halt of a vacant slot is flagged and dropped
        bus.halt_valid = 1'b1;
        bus.halt_wfid  = ID_W'(7);
        tick();
        bus.halt_valid = 1'b0;
        #2;
        check("err_vacant_halt", bus.err, 1);
        check("err_fifo_unchanged", bus.done_valid, 0);
        tick();
        check("err_sticky", bus.err, 1);
`else
        check("err_tied_low", bus.err, 0);
`endif

        check("new_sb_empty", exp_new.size(), 0);
        check("done_sb_empty", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
